// File: rtl/decoder_scan_pkg.sv
// Shared types, defaults and channel-ordering helpers for the decoder scan sequencer.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StBlank
    } scan_state_e;

    localparam int unsigned DefDwellW      = 8;
    localparam int unsigned DefBlankCycles = 2;

    // Lowest set bit of the channel mask; 0 for an empty mask.
    function automatic logic [1:0] first_channel(input logic [3:0] mask);
        first_channel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first_channel = 2'(i);
        end
    endfunction

    // Next enabled channel after cur, ascending with wrap-around.
    function automatic logic [1:0] next_channel(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] cand;
        logic       found;
        next_channel = cur;
        found        = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = cur + 2'(i);
            if (!found && mask[cand]) begin
                next_channel = cand;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter timing both the enable-high dwell and the blanking gap.
module scan_dwell_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans a 2-to-4 decoder through its channels with a per-channel dwell and blanking gap.
// Optional DECODER_SCAN_CHANNEL_MASK_EN adds ch_mask to restrict the visited channels.
module decoder_scan_sequencer
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL_W      = DefDwellW,
    parameter int unsigned BLANK_CYCLES = DefBlankCycles
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_CHANNEL_MASK_EN
    input  logic [3:0]         ch_mask,
`endif
    output logic [1:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               wrap
);

    localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned CntW   = (DWELL_W > BlankW) ? DWELL_W : BlankW;
    localparam logic [CntW-1:0] BlankLoad = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [3:0] mask_in;
`ifdef DECODER_SCAN_CHANNEL_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = 4'hF;
`endif

    scan_state_e        state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dload_q, dload_d;
    logic [3:0]         mask_q, mask_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CntW-1:0]    cnt_val;
    logic [DWELL_W-1:0] dwell_m1;
    logic [1:0]         nxt_ch;
    logic               nxt_wrap;

    // Dwell is held as D-1 so a zero request still gives one enable cycle.
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign nxt_ch   = next_channel(mask_q, sel_q);
    assign nxt_wrap = (nxt_ch == first_channel(mask_q));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wrap_d   = 1'b0;
        dload_d  = dload_q;
        mask_d   = mask_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !stop && (mask_in != 4'b0000)) begin
                    state_d  = StActive;
                    sel_d    = first_channel(mask_in);
                    dload_d  = dwell_m1;
                    mask_d   = mask_in;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(dwell_m1);
                end
            end
            StActive: begin
                if (stop) begin
                    state_d  = StIdle;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        sel_d   = nxt_ch;
                        wrap_d  = nxt_wrap;
                        cnt_val = CntW'(dload_q);
                    end else begin
                        state_d = StBlank;
                        cnt_val = BlankLoad;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StBlank: begin
                if (stop) begin
                    state_d  = StIdle;
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d  = StActive;
                    sel_d    = nxt_ch;
                    wrap_d   = nxt_wrap;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(dload_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            wrap_q  <= 1'b0;
            dload_q <= '0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
            dload_q <= dload_d;
            mask_q  <= mask_d;
        end
    end

    scan_dwell_counter #(
        .Width(CntW)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    assign sel  = sel_q;
    assign en   = (state_q == StActive);
    assign busy = (state_q != StIdle);
    assign wrap = wrap_q;

endmodule

// File: doc/decoder_scan_sequencer.md
DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input.
REQ-002 Parameter: BLANK_CYCLES, default 2, enable-low gap between channels; 0 means no gap.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin scanning.
REQ-006 Port: stop  input  1  request to abort scanning.
REQ-007 Port: dwell  input  DWELL_W  enable-high cycles per channel, sampled on an accepted start.
REQ-008 Port: sel  output  2  channel index to the downstream 2-to-4 decoder select input.
REQ-009 Port: en  output  1  enable to the downstream decoder.
REQ-010 Port: busy  output  1  high in any state other than IDLE.
REQ-011 Port: wrap  output  1  one-cycle pulse when the scan returns to the first channel.

Function
REQ-012 The FSM shall have three states: IDLE, ACTIVE and BLANK.
REQ-013 In IDLE the block shall drive en=0, busy=0, wrap=0, and sel shall hold its last value.
REQ-014 start sampled high in IDLE with stop low shall latch D=max(dwell,1) and the first channel, then enter ACTIVE on the next edge.
REQ-015 The first cycle of ACTIVE shall show en=1, busy=1 and sel=0; start-to-en latency is exactly 1 cycle.
REQ-016 en shall stay high for exactly D consecutive cycles per channel.
REQ-017 After D cycles in ACTIVE the FSM shall enter BLANK with en=0 and sel held, for BLANK_CYCLES cycles.
REQ-018 If BLANK_CYCLES=0, the FSM shall go directly ACTIVE to ACTIVE: sel advances and en stays high.
REQ-019 On leaving BLANK, sel shall advance to the next channel and en shall rise on the same edge, so sel is never changing while en=1.
REQ-020 sel shall wrap from 3 to 0, and wrap shall be high for exactly the first ACTIVE cycle of that return to 0; it is not asserted on the initial start.
REQ-021 start while busy shall be ignored, and changes to dwell while busy shall have no effect.
REQ-022 stop sampled high in any state shall force IDLE on the next edge, with en=0 in that cycle.
REQ-023 If start and stop are high together in IDLE, stop wins and the block stays in IDLE.
REQ-024 The dwell counter shall be DWELL_W bits wide and shall not overflow: the maximum dwell is 2^DWELL_W-1 cycles.

Reset
REQ-025 rst high shall immediately, without a clock edge, force IDLE, sel=0, en=0, busy=0, wrap=0, and clear all counters.
REQ-026 Reset mid-scan shall discard the latched dwell; scanning resumes only on a fresh start after rst is released.

Configuration
REQ-027 Macro DECODER_SCAN_CHANNEL_MASK_EN, when defined, shall add input ch_mask [3:0], sampled on an accepted start.
REQ-028 With the macro defined, sel shall visit only channels whose mask bit is 1, in ascending order with wrap-around.
REQ-029 With the macro defined, the first active channel is the lowest set mask bit, and wrap pulses when the scan re-enters that channel.
REQ-030 With the macro defined, start with ch_mask=0000 shall be ignored.
REQ-031 Without the macro, the port shall be absent and all four channels shall be scanned.

Structure
REQ-032 Package decoder_scan_pkg shall hold the state typedef (IDLE/ACTIVE/BLANK) and default constants for DWELL_W and BLANK_CYCLES.
REQ-033 One sub-module, scan_dwell_counter, shall implement the loadable down-counter shared by the ACTIVE and BLANK timing.

Verification
REQ-034 Reset then idle: rst=1, then 0 -> sel=0, en=0, busy=0, wrap=0 held for 10 cycles.
REQ-035 dwell=3, BLANK_CYCLES=2, start pulse -> en pattern 111 00 repeating; sel 0,1,2,3,0; wrap high one cycle at the second sel=0.
REQ-036 dwell=0 -> en high exactly 1 cycle per channel; with BLANK_CYCLES=0, sel increments every cycle and en stays high.
REQ-037 stop asserted on the 2nd ACTIVE cycle of sel=2 -> next cycle en=0, busy=0; later start with stop high -> no activity.
REQ-038 rst asserted mid-BLANK -> outputs cleared immediately; start after release -> scan restarts at sel=0 with the new dwell.
REQ-039 Macro defined, ch_mask=1010, dwell=2 -> sel 1,3,1; wrap at the second sel=1; ch_mask=0000 with start -> busy stays 0.
